// File: rtl/sync_fifo_ctrl.sv
// fifo_ctrl: pointer and flag control for sync_fifo.
// Owns the read/write pointers, the registered empty/full flags and the
// array write enable. The storage array lives in the parent.
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_i,
  input  logic                  rd_i,
  output logic [ADDR_WIDTH-1:0] wr_ptr_o,
  output logic [ADDR_WIDTH-1:0] rd_ptr_o,
  output logic                  we_o,
  output logic                  empty_o,
  output logic                  full_o
);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  we;
  logic                  re;

  // A pop only happens when something is stored.
  assign re = rd_i & ~empty_q;
  // When full, a write is still accepted if the same edge pops the head:
  // the freed slot is exactly the one the write pointer addresses.
  assign we = wr_i & (~full_q | rd_i);

  // Next-state for pointers and flags; flags follow the pointers in the same edge.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    empty_d  = empty_q;
    full_d   = full_q;
    if (we) wr_ptr_d = wr_ptr_q + 1'b1;
    if (re) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({we, re})
      2'b10: begin
        empty_d = 1'b0;
        full_d  = (wr_ptr_d == rd_ptr_q);
      end
      2'b01: begin
        full_d  = 1'b0;
        empty_d = (rd_ptr_d == wr_ptr_q);
      end
      default: begin
        empty_d = empty_q;
        full_d  = full_q;
      end
    endcase
  end

  // State registers with asynchronous reset (reset_n is active-high here).
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign we_o     = we & ~reset_n;
  assign empty_o  = empty_q;
  assign full_o   = full_q;

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// Depth is 2**ADDR_WIDTH; r_data always shows the head entry while not empty.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  empty,
  output logic                  full
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  we;

  fifo_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ctrl (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_i     (wr),
    .rd_i     (rd),
    .wr_ptr_o (wr_ptr),
    .rd_ptr_o (rd_ptr),
    .we_o     (we),
    .empty_o  (empty),
    .full_o   (full)
  );

  // Storage array; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_ptr] <= w_data;
  end

  // Fall-through read: head entry is visible without a pop.
  assign r_data = mem_q[rd_ptr];

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: self-checking bench for sync_fifo (DATA_WIDTH=8, ADDR_WIDTH=3).
// Reference model is a plain queue with the FIFO acceptance rules.
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic [DW-1:0] r_data;
  logic          empty;
  logic          full;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] q [$];

  sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wr      (wr),
    .rd      (rd),
    .w_data  (w_data),
    .r_data  (r_data),
    .empty   (empty),
    .full    (full)
  );

  always #5 clk = ~clk;

  // One clock cycle of stimulus; the model applies the same edge's effect.
  task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d);
    bit do_r, do_w;
    wr = w; rd = r; w_data = d;
    @(posedge clk);
    do_r = r && (q.size() > 0);
    do_w = w && ((q.size() < DEPTH) || do_r);
    if (do_r) void'(q.pop_front());
    if (do_w) q.push_back(d);
    #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_errors++; $display("FAIL reset_full: got %b want 0", full); end
    reset_n = 1'b0;
    q.delete();
    cycle(0, 0, '0);
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL post_reset_empty: got %b want 1", empty); end
  endtask

  task automatic test_fill;
    logic [DW-1:0] d;
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'hF0 + 8'(i);
      cycle(1, 0, d);
      n_checks++; if (empty !== 1'b0) begin n_errors++; $display("FAIL fill_empty[%0d]: got %b want 0", i, empty); end
      n_checks++; if (full !== (i == DEPTH - 1)) begin n_errors++; $display("FAIL fill_full[%0d]: got %b want %b", i, full, (i == DEPTH - 1)); end
      n_checks++; if (r_data !== 8'hF0) begin n_errors++; $display("FAIL fill_rdata[%0d]: got %h want f0", i, r_data); end
    end
  endtask

  task automatic test_drain;
    logic [DW-1:0] exp;
    for (int i = 0; i < DEPTH; i++) begin
      exp = 8'hF0 + 8'(i);
      n_checks++; if (r_data !== exp) begin n_errors++; $display("FAIL drain_rdata[%0d]: got %h want %h", i, r_data, exp); end
      cycle(0, 1, '0);
      n_checks++; if (full !== 1'b0) begin n_errors++; $display("FAIL drain_full[%0d]: got %b want 0", i, full); end
      n_checks++; if (empty !== (i == DEPTH - 1)) begin n_errors++; $display("FAIL drain_empty[%0d]: got %b want %b", i, empty, (i == DEPTH - 1)); end
    end
  endtask

  task automatic test_overflow;
    logic [DW-1:0] exp;
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, 8'hF0 + 8'(i));
    cycle(1, 0, 8'hAA);
    n_checks++; if (full !== 1'b1) begin n_errors++; $display("FAIL ovf_full: got %b want 1", full); end
    n_checks++; if (r_data !== 8'hF0) begin n_errors++; $display("FAIL ovf_head: got %h want f0", r_data); end
    for (int i = 0; i < DEPTH; i++) begin
      exp = 8'hF0 + 8'(i);
      n_checks++; if (r_data !== exp) begin n_errors++; $display("FAIL ovf_drain[%0d]: got %h want %h", i, r_data, exp); end
      cycle(0, 1, '0);
    end
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL ovf_empty_end: got %b want 1", empty); end
  endtask

  task automatic test_underflow;
    cycle(0, 1, '0);
    cycle(0, 1, '0);
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL udf_empty: got %b want 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_errors++; $display("FAIL udf_full: got %b want 0", full); end
    cycle(1, 0, 8'h11);
    n_checks++; if (empty !== 1'b0) begin n_errors++; $display("FAIL udf_wr_empty: got %b want 0", empty); end
    n_checks++; if (r_data !== 8'h11) begin n_errors++; $display("FAIL udf_wr_rdata: got %h want 11", r_data); end
    cycle(0, 1, '0);
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL udf_pop_empty: got %b want 1", empty); end
  endtask

  task automatic test_full_wr_rd;
    logic [DW-1:0] exp;
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, 8'hF0 + 8'(i));
    cycle(1, 1, 8'hAB);
    n_checks++; if (full !== 1'b1) begin n_errors++; $display("FAIL fullrw_full: got %b want 1", full); end
    n_checks++; if (r_data !== 8'hF1) begin n_errors++; $display("FAIL fullrw_head: got %h want f1", r_data); end
    for (int i = 0; i < DEPTH; i++) begin
      exp = (i == DEPTH - 1) ? 8'hAB : 8'hF1 + 8'(i);
      n_checks++; if (r_data !== exp) begin n_errors++; $display("FAIL fullrw_drain[%0d]: got %h want %h", i, r_data, exp); end
      cycle(0, 1, '0);
    end
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL fullrw_empty_end: got %b want 1", empty); end
  endtask

  task automatic test_simultaneous;
    for (int i = 0; i < 3; i++) cycle(1, 0, 8'($urandom));
    for (int i = 0; i < 10; i++) begin
      cycle(1, 1, 8'($urandom));
      n_checks++; if (r_data !== q[0]) begin n_errors++; $display("FAIL sim_rdata[%0d]: got %h want %h", i, r_data, q[0]); end
      n_checks++; if (empty !== 1'b0 || full !== 1'b0) begin n_errors++; $display("FAIL sim_flags[%0d]: got e=%b f=%b want e=0 f=0", i, empty, full); end
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (r_data !== q[0]) begin n_errors++; $display("FAIL sim_drain[%0d]: got %h want %h", i, r_data, q[0]); end
      cycle(0, 1, '0);
    end
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL sim_empty_end: got %b want 1", empty); end
  endtask

  task automatic test_mid_reset;
    for (int i = 0; i < 5; i++) cycle(1, 0, 8'($urandom));
    #2;
    reset_n = 1'b1;
    #1;
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL mrst_empty: got %b want 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_errors++; $display("FAIL mrst_full: got %b want 0", full); end
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    q.delete();
    cycle(1, 0, 8'h55);
    n_checks++; if (r_data !== 8'h55) begin n_errors++; $display("FAIL mrst_rdata: got %h want 55", r_data); end
    n_checks++; if (empty !== 1'b0) begin n_errors++; $display("FAIL mrst_wr_empty: got %b want 0", empty); end
  endtask

  task automatic test_random;
    logic w, r;
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 99) < ((i / 50) % 2 ? 70 : 35));
      r = ($urandom_range(0, 99) < ((i / 50) % 2 ? 35 : 70));
      cycle(w, r, 8'($urandom));
      n_checks++; if (empty !== (q.size() == 0)) begin n_errors++; $display("FAIL rnd_empty[%0d]: got %b want %b", i, empty, (q.size() == 0)); end
      n_checks++; if (full !== (q.size() == DEPTH)) begin n_errors++; $display("FAIL rnd_full[%0d]: got %b want %b", i, full, (q.size() == DEPTH)); end
      if (q.size() > 0) begin
        n_checks++; if (r_data !== q[0]) begin n_errors++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, r_data, q[0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_overflow();
    test_underflow();
    test_full_wr_rd();
    test_simultaneous();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
